// File: rtl/key_bounce_gen.sv
// Emulates a bouncing mechanical key: each change of the requested level produces
// pseudo-random LFSR-timed toggles, then a forced settled level held for a quiet period.
module key_bounce_gen #(
  parameter int          BOUNCE_LEN = 250000,
  parameter int          HOLD_LEN   = 1500000,
  parameter int          GAP_W      = 12,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_cmd,
  output logic key_bounce,
  output logic busy,
  output logic settled
);

  localparam int BW = (BOUNCE_LEN > 1) ? $clog2(BOUNCE_LEN) : 1;
  localparam int HW = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;
  localparam logic [BW-1:0] BOUNCE_LAST = BW'(BOUNCE_LEN - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_HOLD} state_t;

  state_t           r_state;
  logic             r_cmd_s1;
  logic             r_cmd_s2;
  logic [15:0]      r_lfsr;
  logic             r_target;
  logic             r_key;
  logic             r_settled;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [BW-1:0]    r_bounce_cnt;
  logic [HW-1:0]    r_hold_cnt;

  logic [15:0]      w_lfsr_next;
  logic [GAP_W-1:0] w_gap;

  // Galois form, shifting right, taps x^16+x^14+x^13+x^11+1
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_gap       = (r_lfsr[GAP_W-1:0] == '0) ? GAP_W'(1) : r_lfsr[GAP_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_s1 <= IDLE_LEVEL;
      r_cmd_s2 <= IDLE_LEVEL;
      r_lfsr   <= LFSR_SEED;
    end else begin
      r_cmd_s1 <= key_cmd;
      r_cmd_s2 <= r_cmd_s1;
      r_lfsr   <= w_lfsr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_target     <= IDLE_LEVEL;
      r_key        <= IDLE_LEVEL;
      r_settled    <= IDLE_LEVEL;
      r_gap_cnt    <= '0;
      r_bounce_cnt <= '0;
      r_hold_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_key <= r_settled;
          if (r_cmd_s2 != r_settled) begin
            r_target     <= r_cmd_s2;
            r_key        <= ~r_settled;
            r_gap_cnt    <= w_gap;
            r_bounce_cnt <= '0;
            r_state      <= S_BOUNCE;
          end
        end
        S_BOUNCE: begin
          r_bounce_cnt <= r_bounce_cnt + 1'b1;
          r_gap_cnt    <= r_gap_cnt - 1'b1;
          if (r_gap_cnt == GAP_W'(1)) begin
            r_key     <= ~r_key;
            r_gap_cnt <= w_gap;
          end
          // End of window wins over a toggle landing on the same edge
          if (r_bounce_cnt == BOUNCE_LAST) begin
            r_key      <= r_target;
            r_settled  <= r_target;
            r_hold_cnt <= '0;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_key      <= r_settled;
          r_hold_cnt <= r_hold_cnt + 1'b1;
          if (r_hold_cnt == HOLD_LAST) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign key_bounce = r_key;
  assign settled    = r_settled;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed bench for key_bounce_gen with a small LFSR reference for toggle timing.
module tb_key_bounce_gen;

  localparam int          BL   = 64;
  localparam int          HL   = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_cmd = 1'b0;
  logic key_bounce;
  logic busy;
  logic settled;

  int n_chk = 0;
  int n_fail = 0;
  int cyc;

  key_bounce_gen #(
    .BOUNCE_LEN(BL),
    .HOLD_LEN  (HL),
    .GAP_W     (3),
    .LFSR_SEED (SEED),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_cmd   (key_cmd),
    .key_bounce(key_bounce),
    .busy      (busy),
    .settled   (settled)
  );

  always #5 clk = ~clk;

  // Edges since reset release; edge k uses the LFSR advanced k-1 times from seed
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [15:0] adv(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int gapv(input logic [15:0] l);
    int g;
    g = int'(l[2:0]);
    return (g == 0) ? 1 : g;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input string nm);
    key_cmd = 1'b0;
    rst_n   = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    n_chk++;
    if ({key_bounce, settled, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s: outputs kb/settled/busy=%b required 000", nm, {key_bounce, settled, busy});
    end
    for (int i = 0; i < 100; i++) begin
      step;
      n_chk++;
      if ({key_bounce, settled, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s idle cycle %0d: kb/settled/busy=%b required 000", nm, i, {key_bounce, settled, busy});
      end
    end
  endtask

  // One full bounce+hold event toward target, checked edge by edge against the LFSR reference.
  // p_start/p_len: glitch key_cmd to p_val during the event; abort_at: assert reset after that edge.
  task automatic run_event(input logic target, input bit drive, input int p_start, input int p_len,
                           input logic p_val, input int abort_at, input string nm);
    logic        lvl;
    logic        lvl_old;
    logic        prev;
    logic [15:0] l;
    int          gap;
    int          tog_m;
    int          tog_d;
    lvl = ~target;
    if (drive) begin
      key_cmd = target;
      for (int q = 0; q < 2; q++) begin
        step;
        n_chk++;
        if (key_bounce !== lvl || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s sync delay %0d: kb=%b busy=%b required kb=%b busy=0", nm, q, key_bounce, busy, lvl);
        end
      end
    end
    step;
    lvl = ~lvl;
    n_chk++;
    if (key_bounce !== lvl || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s first toggle: kb=%b busy=%b required kb=%b busy=1", nm, key_bounce, busy, lvl);
    end
    l = SEED;
    for (int k = 1; k < cyc; k++) l = adv(l);
    gap   = gapv(l);
    tog_m = 1;
    tog_d = 1;
    prev  = key_bounce;
    for (int j = 1; j <= BL + HL; j++) begin
      if (j == p_start) key_cmd = p_val;
      if (j == p_start + p_len) key_cmd = target;
      l = adv(l);
      lvl_old = lvl;
      if (j < BL) begin
        if (gap == 1) begin
          lvl = ~lvl;
          gap = gapv(l);
        end else begin
          gap--;
        end
      end else begin
        lvl = target;
      end
      if (lvl != lvl_old) tog_m++;
      step;
      if (key_bounce !== prev) tog_d++;
      prev = key_bounce;
      n_chk++;
      if (key_bounce !== lvl) begin
        n_fail++;
        $display("FAIL %s level at j=%0d: kb=%b required %b", nm, j, key_bounce, lvl);
      end
      n_chk++;
      if (busy !== (j < BL + HL)) begin
        n_fail++;
        $display("FAIL %s busy at j=%0d: busy=%b required %b", nm, j, busy, (j < BL + HL));
      end
      n_chk++;
      if (settled !== ((j >= BL) ? target : ~target)) begin
        n_fail++;
        $display("FAIL %s settled at j=%0d: settled=%b required %b", nm, j, settled, (j >= BL) ? target : ~target);
      end
      if (j == abort_at) begin
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({key_bounce, settled, busy} !== 3'b000) begin
          n_fail++;
          $display("FAIL %s async reset: kb/settled/busy=%b required 000", nm, {key_bounce, settled, busy});
        end
        return;
      end
    end
    n_chk++;
    if (tog_d != tog_m) begin
      n_fail++;
      $display("FAIL %s toggle count: got %0d required %0d", nm, tog_d, tog_m);
    end
  endtask

  task automatic test_press;
    run_event(1'b1, 1'b1, 0, 0, 1'b0, 0, "press");
  endtask

  task automatic test_release;
    run_event(1'b0, 1'b1, 0, 0, 1'b0, 0, "release");
  endtask

  task automatic test_ignored;
    run_event(1'b1, 1'b1, 10, 10, 1'b0, 0, "ignored");
    for (int i = 0; i < 20; i++) begin
      step;
      n_chk++;
      if ({key_bounce, settled, busy} !== 3'b110) begin
        n_fail++;
        $display("FAIL ignored quiet %0d: kb/settled/busy=%b required 110", i, {key_bounce, settled, busy});
      end
    end
  endtask

  task automatic test_late_mismatch;
    run_event(1'b0, 1'b1, 40, 1000, 1'b1, 0, "late_first");
    run_event(1'b1, 1'b0, 0, 0, 1'b0, 0, "late_second");
  endtask

  task automatic test_reset_mid;
    test_reset("reset_pre_mid");
    run_event(1'b1, 1'b1, 0, 0, 1'b0, 30, "mid_abort");
    test_reset("reset_post_mid");
    run_event(1'b1, 1'b1, 0, 0, 1'b0, 0, "replay");
  endtask

  initial begin
    test_reset("reset");
    test_press;
    test_release;
    test_ignored;
    test_late_mismatch;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
